clb_cfg_loader: RTL and testbench

- Configuration front-end sitting directly upstream of the 4x4 CLB array. It drives every operand-select, op-select and column-bypass input of the array.
- Software or a host FSM writes per-cell and per-column words into a shadow bank over a valid/ready port.
- A commit request atomically copies the shadow bank into the active bank that drives the array. The array never sees a half-written configuration.

---
 rtl/clb_cfg_pkg.sv | 21 ++
 rtl/clb_cfg_bank.sv | 23 ++
 rtl/clb_cfg_loader.sv | 162 ++++++++++++++++
 tb/tb_clb_cfg_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clb_cfg_pkg.sv
// Shared constants and types for the CLB configuration loader.
package clb_cfg_pkg;

   localparam int CELL_CNT  = 16;
   localparam int COL_CNT   = 4;
   localparam int ENTRY_CNT = CELL_CNT + COL_CNT;

   localparam logic [4:0] ADDR_BYP_BASE = 5'd16;
   localparam logic [4:0] ADDR_LAST     = 5'd19;

   // Field offsets inside a cell write word
   localparam int SEL0_OFS  = 0;
   localparam int SEL1_OFS  = 3;
   localparam int SELOP_OFS = 6;

   typedef enum logic {
      IDLE = 1'b0,
      SWAP = 1'b1
   } state_t;

endpackage

// File: rtl/clb_cfg_bank.sv
// Configuration register bank with per-bit load enable and async reset.
module clb_cfg_bank
   import clb_cfg_pkg::*;
#(
   parameter int W = 144
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Load only the bits whose enable is set; everything else holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else begin
         q <= (q & ~en) | (d & en);
      end
   end

endmodule

// File: rtl/clb_cfg_loader.sv
// Shadow/active configuration loader for the 4x4 CLB array. Writes land in a
// shadow bank; a commit copies the whole shadow into the active bank in one edge.
module clb_cfg_loader
   import clb_cfg_pkg::*;
#(
   parameter int SEL_W = 3,
   parameter int OP_W  = 2,
   parameter int BYP_W = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic [4:0]                  wr_addr,
   input  logic [2*SEL_W+OP_W-1:0]     wr_data,
   input  logic                        commit_req,
   output logic                        commit_done,
   output logic                        cfg_live,
   output logic                        err_incomplete,
   output logic                        err_addr,
   output logic [CELL_CNT*SEL_W-1:0]   cfg_sel0,
   output logic [CELL_CNT*SEL_W-1:0]   cfg_sel1,
   output logic [CELL_CNT*OP_W-1:0]    cfg_selop,
   output logic [COL_CNT*BYP_W-1:0]    cfg_bypass
);

   // Bank layout: sel0 | sel1 | selop | bypass, from LSB upward
   localparam int SEL_TOT    = CELL_CNT * SEL_W;
   localparam int OP_TOT     = CELL_CNT * OP_W;
   localparam int BYP_TOT    = COL_CNT * BYP_W;
   localparam int SEL1_BASE  = SEL_TOT;
   localparam int SELOP_BASE = 2 * SEL_TOT;
   localparam int BYP_BASE   = 2 * SEL_TOT + OP_TOT;
   localparam int BANK_W     = BYP_BASE + BYP_TOT;

   state_t                 state;
   state_t                 state_nxt;
   logic                   accept;
   logic                   legal;
   logic                   commit_ok;
   logic                   commit_fail;
   logic [3:0]             cell_idx;
   logic [1:0]             col_idx;
   logic [ENTRY_CNT-1:0]   mask;
   logic [ENTRY_CNT-1:0]   mask_set;
   logic [ENTRY_CNT-1:0]   mask_nxt;
   logic [BANK_W-1:0]      shadow_en;
   logic [BANK_W-1:0]      shadow_d;
   logic [BANK_W-1:0]      shadow_q;
   logic [BANK_W-1:0]      active_en;
   logic [BANK_W-1:0]      active_q;

   assign wr_ready = (state == IDLE);
   assign accept   = wr_valid && wr_ready;
   assign legal    = (wr_addr <= ADDR_LAST);
   assign cell_idx = wr_addr[3:0];
   assign col_idx  = wr_addr[1:0];

   // The mask seen by a commit includes a write accepted in the same cycle.
   assign mask_set = (accept && legal) ? ({{(ENTRY_CNT-1){1'b0}}, 1'b1} << wr_addr) : '0;
   assign mask_nxt = mask | mask_set;

   // Decode an accepted legal write into shadow field enables and data.
   always_comb begin
      shadow_en = '0;
      shadow_d  = '0;
      if (accept && legal) begin
         if (wr_addr < ADDR_BYP_BASE) begin
            shadow_en[cell_idx*SEL_W +: SEL_W]              = '1;
            shadow_d [cell_idx*SEL_W +: SEL_W]              = wr_data[SEL0_OFS +: SEL_W];
            shadow_en[SEL1_BASE + cell_idx*SEL_W +: SEL_W]  = '1;
            shadow_d [SEL1_BASE + cell_idx*SEL_W +: SEL_W]  = wr_data[SEL1_OFS +: SEL_W];
            shadow_en[SELOP_BASE + cell_idx*OP_W +: OP_W]   = '1;
            shadow_d [SELOP_BASE + cell_idx*OP_W +: OP_W]   = wr_data[SELOP_OFS +: OP_W];
         end else begin
            shadow_en[BYP_BASE + col_idx*BYP_W +: BYP_W]    = '1;
            shadow_d [BYP_BASE + col_idx*BYP_W +: BYP_W]    = wr_data[BYP_W-1:0];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: a commit is honoured only when every entry has been written.
   always_comb begin
      state_nxt   = state;
      commit_ok   = 1'b0;
      commit_fail = 1'b0;
      case (state)
         IDLE: begin
            if (commit_req) begin
               if (&mask_nxt) begin
                  commit_ok = 1'b1;
                  state_nxt = SWAP;
               end else begin
                  commit_fail = 1'b1;
               end
            end
         end
         SWAP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Written mask, sticky errors and commit status.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask           <= '0;
         err_incomplete <= 1'b0;
         err_addr       <= 1'b0;
         cfg_live       <= 1'b0;
         commit_done    <= 1'b0;
      end else begin
         commit_done <= (state == SWAP);
         if (state == SWAP) begin
            mask           <= '0;
            cfg_live       <= 1'b1;
            err_incomplete <= 1'b0;
            err_addr       <= 1'b0;
         end else begin
            mask <= mask_nxt;
            if (commit_fail) begin
               err_incomplete <= 1'b1;
            end
            if (accept && !legal) begin
               err_addr <= 1'b1;
            end
         end
      end
   end

   assign active_en = {BANK_W{state == SWAP}};

   clb_cfg_bank #(.W(BANK_W)) u_shadow (
      .clk (clk),
      .rst (rst),
      .en  (shadow_en),
      .d   (shadow_d),
      .q   (shadow_q)
   );

   clb_cfg_bank #(.W(BANK_W)) u_active (
      .clk (clk),
      .rst (rst),
      .en  (active_en),
      .d   (shadow_q),
      .q   (active_q)
   );

   assign cfg_sel0   = active_q[SEL_TOT-1:0];
   assign cfg_sel1   = active_q[SEL1_BASE +: SEL_TOT];
   assign cfg_selop  = active_q[SELOP_BASE +: OP_TOT];
   assign cfg_bypass = active_q[BYP_BASE +: BYP_TOT];

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Directed bench for clb_cfg_loader.
module tb_clb_cfg_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_valid;
   logic        wr_ready;
   logic [4:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        commit_req;
   logic        commit_done;
   logic        cfg_live;
   logic        err_incomplete;
   logic        err_addr;
   logic [47:0] cfg_sel0;
   logic [47:0] cfg_sel1;
   logic [31:0] cfg_selop;
   logic [15:0] cfg_bypass;

   int n_checks = 0;
   int n_errors = 0;

   // Shadow model (what has been written) and active model (last commit)
   logic [7:0] m_cell [16];
   logic [3:0] m_byp  [4];
   logic [7:0] a_cell [16];
   logic [3:0] a_byp  [4];

   clb_cfg_loader dut (
      .clk            (clk),
      .rst            (rst),
      .wr_valid       (wr_valid),
      .wr_ready       (wr_ready),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .commit_req     (commit_req),
      .commit_done    (commit_done),
      .cfg_live       (cfg_live),
      .err_incomplete (err_incomplete),
      .err_addr       (err_addr),
      .cfg_sel0       (cfg_sel0),
      .cfg_sel1       (cfg_sel1),
      .cfg_selop      (cfg_selop),
      .cfg_bypass     (cfg_bypass)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_write(input logic [4:0] a, input logic [7:0] d);
      if (a < 5'd16) m_cell[a[3:0]] = d;
      else if (a < 5'd20) m_byp[a[1:0]] = d[3:0];
   endtask

   task automatic take_commit();
      for (int i = 0; i < 16; i++) a_cell[i] = m_cell[i];
      for (int c = 0; c < 4; c++) a_byp[c] = m_byp[c];
   endtask

   task automatic clear_models();
      for (int i = 0; i < 16; i++) begin m_cell[i] = '0; a_cell[i] = '0; end
      for (int c = 0; c < 4; c++) begin m_byp[c] = '0; a_byp[c] = '0; end
   endtask

   task automatic check_active(input string tag);
      logic [47:0] e0;
      logic [47:0] e1;
      logic [31:0] eo;
      logic [15:0] eb;
      for (int i = 0; i < 16; i++) begin
         e0[3*i +: 3] = a_cell[i][2:0];
         e1[3*i +: 3] = a_cell[i][5:3];
         eo[2*i +: 2] = a_cell[i][7:6];
      end
      for (int c = 0; c < 4; c++) eb[4*c +: 4] = a_byp[c];
      check({tag, "_sel0"}, cfg_sel0, e0);
      check({tag, "_sel1"}, cfg_sel1, e1);
      check({tag, "_selop"}, cfg_selop, eo);
      check({tag, "_bypass"}, cfg_bypass, eb);
   endtask

   // Present a write, wait (bounded) for acceptance, then drop wr_valid.
   task automatic do_write(input logic [4:0] a, input logic [7:0] d);
      int n = 0;
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      while (!wr_ready && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      if (n == 8) check("wr_stall_bound", wr_ready, 1'b1);
      @(posedge clk); #1;
      wr_valid = 1'b0;
      model_write(a, d);
   endtask

   // Last write and commit request in the same cycle; returns inside SWAP.
   task automatic write_commit(input logic [4:0] a, input logic [7:0] d);
      wr_valid   = 1'b1;
      wr_addr    = a;
      wr_data    = d;
      commit_req = 1'b1;
      @(posedge clk); #1;
      wr_valid   = 1'b0;
      commit_req = 1'b0;
      model_write(a, d);
   endtask

   initial begin
      rst        = 1'b1;
      wr_valid   = 1'b0;
      wr_addr    = '0;
      wr_data    = '0;
      commit_req = 1'b0;
      clear_models();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Reset state
      check("rst_wr_ready", wr_ready, 1'b1);
      check("rst_live", cfg_live, 1'b0);
      check("rst_done", commit_done, 1'b0);
      check("rst_err_inc", err_incomplete, 1'b0);
      check("rst_err_addr", err_addr, 1'b0);
      check_active("rst");

      // Commit with nothing written
      commit_req = 1'b1;
      @(posedge clk); #1;
      commit_req = 1'b0;
      check("empty_err_inc", err_incomplete, 1'b1);
      check("empty_wr_ready", wr_ready, 1'b1);
      @(posedge clk); #1;
      check("empty_done", commit_done, 1'b0);
      check("empty_live", cfg_live, 1'b0);
      check_active("empty");

      // Load 19 entries, an illegal write, then a commit that must be refused
      for (int i = 0; i < 16; i++) do_write(5'(i), 8'(i*8 + 3));
      for (int c = 0; c < 3; c++) do_write(5'(16 + c), {4'h0, 4'hA ^ 4'(c)});
      do_write(5'd25, 8'hFF);
      check("illegal_err_addr", err_addr, 1'b1);
      commit_req = 1'b1;
      @(posedge clk); #1;
      commit_req = 1'b0;
      check("partial_err_inc", err_incomplete, 1'b1);
      check("partial_wr_ready", wr_ready, 1'b1);
      check("partial_live", cfg_live, 1'b0);
      check_active("partial");

      // Final entry, then a full commit: done after two edges
      do_write(5'd19, 8'h09);
      commit_req = 1'b1;
      @(posedge clk); #1;
      commit_req = 1'b0;
      check("load_swap_ready", wr_ready, 1'b0);
      check("load_swap_done", commit_done, 1'b0);
      check("load_swap_live", cfg_live, 1'b0);
      @(posedge clk); #1;
      take_commit();
      check("load_done", commit_done, 1'b1);
      check("load_live", cfg_live, 1'b1);
      check("load_err_inc", err_incomplete, 1'b0);
      check("load_err_addr", err_addr, 1'b0);
      check("load_sel0_c0", cfg_sel0[2:0], 3'd3);
      check("load_selop_c15", cfg_selop[31:30], 2'b01);
      check("load_byp_c3", cfg_bypass[15:12], 4'h9);
      check_active("load");
      @(posedge clk); #1;
      check("load_done_pulse", commit_done, 1'b0);

      // Rewrite 19 entries, commit together with the last write, stall a write in SWAP
      for (int i = 0; i < 16; i++) do_write(5'(i), 8'(i*17 + 5));
      for (int c = 0; c < 3; c++) do_write(5'(16 + c), {4'h0, 4'(c + 5)});
      wr_valid   = 1'b1;
      wr_addr    = 5'd19;
      wr_data    = 8'hF6;
      commit_req = 1'b1;
      @(posedge clk); #1;
      commit_req = 1'b0;
      model_write(5'd19, 8'hF6);
      wr_addr = 5'd5;
      wr_data = 8'hFF;
      check("stall_swap_ready", wr_ready, 1'b0);
      @(posedge clk); #1;
      take_commit();
      check("conc_done", commit_done, 1'b1);
      check("conc_byp_c3", cfg_bypass[15:12], 4'h6);
      check("stall_ready_back", wr_ready, 1'b1);
      check_active("conc");
      @(posedge clk); #1;
      wr_valid = 1'b0;
      model_write(5'd5, 8'hFF);
      check("stall_done_pulse", commit_done, 1'b0);
      check_active("stall_active");

      // Cell 5 is already in the shadow and mask: commit succeeds without rewriting it
      for (int i = 0; i < 16; i++) if (i != 5) do_write(5'(i), 8'(i*5 + 1));
      for (int c = 0; c < 3; c++) do_write(5'(16 + c), 8'h03);
      write_commit(5'd19, 8'h0C);
      @(posedge clk); #1;
      take_commit();
      check("mask5_done", commit_done, 1'b1);
      check("mask5_err_inc", err_incomplete, 1'b0);
      check("mask5_sel0", cfg_sel0[17:15], 3'd7);
      check("mask5_selop", cfg_selop[11:10], 2'b11);
      check_active("mask5");

      // Asynchronous reset in the middle of SWAP
      for (int i = 0; i < 16; i++) do_write(5'(i), 8'(i + 8'h40));
      for (int c = 0; c < 3; c++) do_write(5'(16 + c), 8'h0E);
      write_commit(5'd19, 8'h01);
      check("abort_in_swap", wr_ready, 1'b0);
      #2 rst = 1'b1;
      #1;
      clear_models();
      check("abort_live", cfg_live, 1'b0);
      check("abort_done", commit_done, 1'b0);
      check_active("abort");
      @(posedge clk); #1;
      check("abort_done_hold", commit_done, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("abort_done_after", commit_done, 1'b0);
      check("abort_live_after", cfg_live, 1'b0);
      check("abort_wr_ready", wr_ready, 1'b1);
      check_active("abort_after");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
